// File: rtl/bloco_operacional_pkg.sv
// Shared constants for the Horner-evaluation controller and datapath:
// data width and the encodings of the operand selects and operation code.
package bloco_operacional_pkg;
   localparam int W_DEF = 8;

   localparam logic [1:0] SEL_H     = 2'b10;
   localparam logic [1:0] SEL_A     = 2'b01;
   localparam logic [1:0] SEL_C_ADD = 2'b11;
   localparam logic [1:0] SEL_B_ADD = 2'b11;
   localparam logic [1:0] SEL_X     = 2'b01;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;
endpackage

// File: rtl/bloco_operacional_mult_serial.sv
// Iterative shift-add multiplier: operands are latched on start and one
// partial product is accumulated per edge, completing W edges later.
module mult_serial #(
   parameter int W = 8
) (
   input  logic         ck,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] product,
   output logic         busy,
   output logic         done
);
   localparam int CW = $clog2(W) + 1;

   logic [W-1:0]  mcand_r;
   logic [W-1:0]  mplier_r;
   logic [W-1:0]  acc_r;
   logic [CW-1:0] cnt_r;
   logic          busy_r;
   logic [W-1:0]  step_s;
   logic          last_s;

   // Next accumulator value and final-step detection
   always_comb begin
      step_s = acc_r + (mplier_r[0] ? mcand_r : {W{1'b0}});
      last_s = busy_r && (cnt_r == CW'(W - 1));
   end

   // Operand latch and one shift-add step per edge while busy
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         mcand_r  <= {W{1'b0}};
         mplier_r <= {W{1'b0}};
         acc_r    <= {W{1'b0}};
         cnt_r    <= {CW{1'b0}};
         busy_r   <= 1'b0;
      end else if (busy_r) begin
         acc_r    <= step_s;
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
         cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
         if (last_s) begin
            busy_r <= 1'b0;
         end else begin
            busy_r <= 1'b1;
         end
      end else if (start) begin
         mcand_r  <= a;
         mplier_r <= b;
         acc_r    <= {W{1'b0}};
         cnt_r    <= {CW{1'b0}};
         busy_r   <= 1'b1;
      end else begin
         busy_r   <= 1'b0;
      end
   end

   // The product is presented on the completing edge so H captures it there
   assign product = step_s;
   assign busy    = busy_r;
   assign done    = last_s;
endmodule

// File: rtl/bloco_operacional.sv
// Datapath for y = (a*x + b)*x + c: X/H/S registers, operand muxes,
// single-cycle adder and a serial multiplier that drives pronto.
module bloco_operacional
   import bloco_operacional_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         ck,
   input  logic         rst,
   input  logic [W-1:0] x_in,
   input  logic [W-1:0] coef_a,
   input  logic [W-1:0] coef_b,
   input  logic [W-1:0] coef_c,
   input  logic         lx,
   input  logic         lh,
   input  logic         ls,
   input  logic         h,
   input  logic [1:0]   m0,
   input  logic [1:0]   m1,
   input  logic [1:0]   m2,
   output logic [W-1:0] y_out,
   output logic         pronto
);
   logic [W-1:0] x_r;
   logic [W-1:0] h_r;
   logic [W-1:0] s_r;
   logic [W-1:0] left_s;
   logic [W-1:0] rm_s;
   logic [W-1:0] ra_s;
   logic [W-1:0] sum_s;
   logic [W-1:0] product_s;
   logic         busy_s;
   logic         done_s;
   logic         idle_s;
   logic         start_s;

   // Operand selection and adder
   always_comb begin
      case (m0)
         SEL_A:   left_s = coef_a;
         default: left_s = h_r;
      endcase
      if (m1[1]) begin
         rm_s = {W{1'b0}};
      end else begin
         rm_s = x_r;
      end
      if (m2 == SEL_B_ADD) begin
         ra_s = (m0 == SEL_C_ADD) ? coef_c : coef_b;
      end else begin
         ra_s = {W{1'b0}};
      end
      sum_s   = left_s + ra_s;
      idle_s  = ~busy_s;
      start_s = idle_s && lh && (h == OP_MUL);
   end

   mult_serial #(.W(W)) u_mult (
      .ck      (ck),
      .rst     (rst),
      .start   (start_s),
      .a       (left_s),
      .b       (rm_s),
      .product (product_s),
      .busy    (busy_s),
      .done    (done_s)
   );

   // Architectural registers; loads are only honoured while idle
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         x_r <= {W{1'b0}};
         h_r <= {W{1'b0}};
         s_r <= {W{1'b0}};
      end else if (idle_s) begin
         if (lx) x_r <= x_in;
         if (ls) s_r <= sum_s;
         if (lh && (h == OP_ADD)) h_r <= sum_s;
      end else if (done_s) begin
         h_r <= product_s;
      end else begin
         h_r <= h_r;
      end
   end

   assign y_out  = s_r;
   assign pronto = ~busy_s;
endmodule

// File: doc/bloco_operacional.md
Name: bloco_operacional

Overview:
- Datapath paired with the controle FSM. It consumes lx, m0, m1, m2, h, ls and lh, and evaluates y = (a*x + b)*x + c in Horner form.
- Holds registers X, H (accumulator) and S (result).
- Has a single-cycle adder and an iterative shift-add multiplier.
- Drives pronto back to the controller: low while a multiplication is in flight.

Parameters:
- W, 8, data width of x, coefficients and all registers; arithmetic is modulo 2^W.

Ports:
- ck  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- x_in  in  W  operand x, sampled when lx=1
- coef_a  in  W  coefficient a, held stable by the system during a computation
- coef_b  in  W  coefficient b, same stability rule
- coef_c  in  W  coefficient c, same stability rule
- lx  in  1  load X
- lh  in  1  load H (starts a multiply if h=1)
- ls  in  1  load S
- h  in  1  operation select: 1=multiply, 0=add
- m0  in  2  left/constant operand select
- m1  in  2  multiply right operand select
- m2  in  2  add right operand enable
- y_out  out  W  S register contents
- pronto  out  1  1 = idle, accepts a load; 0 = multiplier busy

Behaviour:
- Reset (rst=1, any time, asynchronous):
  - X, H, S and all multiplier state go to 0.
  - pronto=1, y_out=0.
  - An in-flight multiply is aborted.
- Left operand L, selected by m0:
  - 00 → H
  - 01 → coef_a
  - 10 → H
  - 11 → H
- Multiply right operand RM, selected by m1:
  - 00 → X
  - 01 → X
  - 1x → zero
- Add right operand RA, selected by m2 and m0:
  - m2=11 → (m0=11 ? coef_c : coef_b)
  - any other m2 → zero
- Adder: SUM = (L + RA) mod 2^W, combinational.
- lx=1 at an edge while idle: X <= x_in.
- lh=1, h=0 at an edge while idle: H <= SUM, written at that edge.
- lh=1, h=1 at an edge while idle (start edge k):
  - L and RM are latched into the multiplier; busy=1 from edge k; pronto=0 from after edge k.
  - One shift-add step per edge, using a log2(W)+1-bit counter.
  - At edge k+W: H <= (L*RM) mod 2^W, busy=0, pronto=1 after that edge.
  - Latency is exactly W cycles.
- ls=1 at an edge while idle: S <= SUM, independent of h.
- Simultaneous loads in one idle cycle are all honoured:
  - lh&h together with ls: the multiply starts and S takes SUM.
  - lx together with lh: the operation uses the old X; X updates at the same edge.
- While busy (pronto=0):
  - lx, lh and ls are ignored; X, S and the running multiply are unaffected.
  - The controller must stall on pronto.
- pronto is driven directly from the inverted busy register; no combinational path from inputs.
- Expected operation sequence (step: signals → effect):
  - B: lx → X
  - C: lh, h=1, m0=01 → H = a*X
  - E: lh, h=0, m0=10, m2=11 → H += b
  - G: lh, h=1, m1=01 → H *= X
  - I: ls, h=0, m0=11, m2=11 → S = H + c

Decomposition:
- Shared package holds:
  - W default
  - m0/m1/m2 encoding constants (SEL_H, SEL_A, SEL_B_ADD, SEL_C_ADD, SEL_X)
  - h encodings OP_ADD=0, OP_MUL=1
- Controller and datapath both import this package.
- One sub-module, mult_serial (W): start, operand a/b, product, busy.
  - Iterative shift-add, W cycles, same ck/rst.
- Muxes, adder and registers stay in bloco_operacional.

Test Plan:
- Reset checks: assert rst mid-operation → y_out=0, pronto=1 immediately, no ck edge required. Release and repeat any load → normal behaviour.
- Full Horner sequence, W=8, a=2, b=3, c=4, x_in=5, driven as above with stalls on pronto → H=10 after C, 13 after E, 65 after G; y_out=69 after I. Each multiply shows pronto=0 for exactly 8 cycles.
- Wrap-around: a=16, x=16 → H=0 after the first multiply. a=255, b=1 → H+b wraps to 0.
- Loads while busy: pulse lx with x_in=9 and ls at busy cycle 3 → X and S unchanged; product correct; pronto returns at edge k+8.
- Reset at busy cycle 4 of a multiply → H=0, pronto=1. A new multiply started afterwards completes normally in 8 cycles.
- Simultaneous loads: ls and lh&h=1 in the same cycle with m0=10, m2=11 → S=H_old+b at that edge while the multiply of H_old*X proceeds.
